// File: rtl/propose_sequencer.sv
`timescale 1ns/1ps
// propose_sequencer: control stage ahead of the propose datapath. It picks a random variable,
// steps the datapath enables in order, then captures and hands off the proposed move.
// Latency from start accept to done: bool 4, discrete 5/6, continuous N+5, reserved type 2.
// Backpressure: none. A start that arrives while busy is dropped, not queued.
// Optional macro PROPOSE_SEQUENCER_FORCE_INDEX_EN adds in_force_index/in_forced_index so the
// index can be forced; the LFSR still advances.
module propose_sequencer #(
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX    = 3,
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8
) (
  input  logic                                         in_clock,
  input  logic                                         in_reset,
  input  logic                                         in_seed_load,
  input  logic [7:0]                                   in_seed,
  input  logic                                         in_start,
`ifdef PROPOSE_SEQUENCER_FORCE_INDEX_EN
  input  logic                                         in_force_index,
  input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  in_forced_index,
`endif
  input  logic [2*(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] in_variable_types,
  input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0]      in_number_of_clauses,
  input  logic                                         in_no_need_to_sample,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_integer_proposed_move,
  input  logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] in_boolean_proposed_move,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_variable_to_be_changed_index,
  output logic                                         out_chosen_variable_is_discrete,
  output logic                                         out_boolean_propose_enable,
  output logic                                         out_random_enable,
  output logic [(2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] out_reduce_enable,
  output logic                                         out_select_segment_enable,
  output logic                                         out_sampler_enable,
  output logic                                         out_busy,
  output logic                                         out_done,
  output logic                                         out_error,
  output logic                                         out_is_boolean,
  output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_proposed_integer,
  output logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] out_proposed_boolean
);

  localparam int VI = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int CI = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int IW = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int V  = 2**VI;
  localparam int C  = 2**CI;
  localparam int CW = CI + 1;

  localparam logic [1:0] TYPE_BOOL     = 2'b00;
  localparam logic [1:0] TYPE_DISCRETE = 2'b01;
  localparam logic [1:0] TYPE_CONT     = 2'b10;
  localparam logic [1:0] TYPE_RESERVED = 2'b11;

  typedef enum logic [3:0] {
    IDLE, PICK, BOOL, DISC_RAND, DISC_CHECK, REDUCE, SELECT, SAMPLE, CAPTURE, DONE
  } state_t;

  state_t         state;
  logic [7:0]     lfsr;
  logic [1:0]     chosen_type;
  logic [CI-1:0]  clause_k;
  logic [CW-1:0]  clause_count;
  logic [VI-1:0]  pick_index;
  logic [1:0]     pick_type;
  logic [CW-1:0]  clauses_sat;
  logic           start_accept;
  logic           lfsr_feedback;

`ifdef PROPOSE_SEQUENCER_FORCE_INDEX_EN
  logic           force_q;
  logic [VI-1:0]  forced_index_q;
`endif

  assign start_accept  = (state == IDLE) && in_start;
  assign lfsr_feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign pick_type     = in_variable_types[{pick_index, 1'b0} +: 2];
  // Clause counts above the register count are clamped to the register count.
  assign clauses_sat   = (in_number_of_clauses > CW'(C)) ? CW'(C) : in_number_of_clauses;

  // Index source: LFSR low bits (already advanced on the accept edge) unless forced.
  always_comb begin
    pick_index = lfsr[VI-1:0];
`ifdef PROPOSE_SEQUENCER_FORCE_INDEX_EN
    if (force_q) pick_index = forced_index_q;
`endif
  end

  // LFSR: seed load wins over the single advance made when a start is accepted.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      lfsr <= 8'h01;
    end else if (in_seed_load) begin
      lfsr <= (in_seed == 8'h00) ? 8'h01 : in_seed;
    end else if (start_accept) begin
      lfsr <= {lfsr[6:0], lfsr_feedback};
    end
  end

`ifdef PROPOSE_SEQUENCER_FORCE_INDEX_EN
  // Force request is captured with the start so PICK sees a stable choice.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      force_q        <= 1'b0;
      forced_index_q <= '0;
    end else if (start_accept) begin
      force_q        <= in_force_index;
      forced_index_q <= in_forced_index;
    end
  end
`endif

  // Sequencer FSM; every output is registered, strobes default low each cycle so
  // at most one enable is ever high.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state                            <= IDLE;
      chosen_type                      <= TYPE_BOOL;
      clause_k                         <= '0;
      clause_count                     <= '0;
      out_variable_to_be_changed_index <= '0;
      out_chosen_variable_is_discrete  <= 1'b0;
      out_boolean_propose_enable       <= 1'b0;
      out_random_enable                <= 1'b0;
      out_reduce_enable                <= '0;
      out_select_segment_enable        <= 1'b0;
      out_sampler_enable               <= 1'b0;
      out_busy                         <= 1'b0;
      out_done                         <= 1'b0;
      out_error                        <= 1'b0;
      out_is_boolean                   <= 1'b0;
      out_proposed_integer             <= '0;
      out_proposed_boolean             <= '0;
    end else begin
      out_boolean_propose_enable <= 1'b0;
      out_random_enable          <= 1'b0;
      out_reduce_enable          <= '0;
      out_select_segment_enable  <= 1'b0;
      out_sampler_enable         <= 1'b0;
      out_done                   <= 1'b0;
      out_error                  <= 1'b0;

      case (state)
        IDLE: begin
          if (in_start) begin
            state    <= PICK;
            out_busy <= 1'b1;
          end
        end

        PICK: begin
          out_variable_to_be_changed_index <= pick_index;
          chosen_type                      <= pick_type;
          out_chosen_variable_is_discrete  <= (pick_type == TYPE_DISCRETE);
          clause_k                         <= '0;
          clause_count                     <= clauses_sat;
          case (pick_type)
            TYPE_BOOL:     state <= BOOL;
            TYPE_DISCRETE: state <= DISC_RAND;
            TYPE_CONT:     state <= (clauses_sat == '0) ? SELECT : REDUCE;
            default:       state <= DONE;
          endcase
        end

        BOOL: begin
          out_boolean_propose_enable <= 1'b1;
          state                      <= CAPTURE;
        end

        DISC_RAND: begin
          out_random_enable <= 1'b1;
          state             <= DISC_CHECK;
        end

        DISC_CHECK: begin
          state <= in_no_need_to_sample ? CAPTURE : SAMPLE;
        end

        REDUCE: begin
          // One clause strobe per cycle, walking k from 0 up to count-1.
          out_reduce_enable <= {{(C-1){1'b0}}, 1'b1} << clause_k;
          if ({1'b0, clause_k} == clause_count - CW'(1)) begin
            state <= SELECT;
          end else begin
            clause_k <= clause_k + CI'(1);
          end
        end

        SELECT: begin
          out_select_segment_enable <= 1'b1;
          state                     <= SAMPLE;
        end

        SAMPLE: begin
          out_sampler_enable <= 1'b1;
          state              <= CAPTURE;
        end

        CAPTURE: begin
          if (chosen_type == TYPE_BOOL) begin
            out_proposed_boolean <= in_boolean_proposed_move;
            out_is_boolean       <= 1'b1;
          end else begin
            out_proposed_integer <= in_integer_proposed_move;
            out_is_boolean       <= 1'b0;
          end
          state <= DONE;
        end

        DONE: begin
          out_done  <= 1'b1;
          out_error <= (chosen_type == TYPE_RESERVED);
          out_busy  <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state    <= IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_propose_sequencer.sv
`timescale 1ns/1ps
// Bench for propose_sequencer: directed vector table, reset abort sequence, random transactions
// compared against a reference built from the ordering/latency rules.
module tb_propose_sequencer;

  localparam int VI = 2;
  localparam int CI = 3;
  localparam int IW = 8;
  localparam int V  = 4;
  localparam int C  = 8;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           seed_load = 1'b0;
  logic [7:0]     seed = 8'h00;
  logic           start = 1'b0;
  logic           force_index = 1'b0;
  logic [VI-1:0]  forced_index = '0;
  logic [2*V-1:0] types = '0;
  logic [CI:0]    nclauses = '0;
  logic           nns = 1'b0;
  logic [IW-1:0]  int_move = '0;
  logic [V-1:0]   bool_move = '0;

  logic [VI-1:0]  idx_o;
  logic           disc_o, bstb, rstb, selstb, smpstb, busy, done, err, isb;
  logic [C-1:0]   redstb;
  logic [IW-1:0]  pint;
  logic [V-1:0]   pbool;

  always #5 clock = ~clock;

  propose_sequencer dut (
    .in_clock                         (clock),
    .in_reset                         (reset_n),
    .in_seed_load                     (seed_load),
    .in_seed                          (seed),
    .in_start                         (start),
`ifdef PROPOSE_SEQUENCER_FORCE_INDEX_EN
    .in_force_index                   (force_index),
    .in_forced_index                  (forced_index),
`endif
    .in_variable_types                (types),
    .in_number_of_clauses             (nclauses),
    .in_no_need_to_sample             (nns),
    .in_integer_proposed_move         (int_move),
    .in_boolean_proposed_move         (bool_move),
    .out_variable_to_be_changed_index (idx_o),
    .out_chosen_variable_is_discrete  (disc_o),
    .out_boolean_propose_enable       (bstb),
    .out_random_enable                (rstb),
    .out_reduce_enable                (redstb),
    .out_select_segment_enable        (selstb),
    .out_sampler_enable               (smpstb),
    .out_busy                         (busy),
    .out_done                         (done),
    .out_error                        (err),
    .out_is_boolean                   (isb),
    .out_proposed_integer             (pint),
    .out_proposed_boolean             (pbool)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] m_lfsr = 8'h01;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [30:0] all_outputs();
    return {idx_o, disc_o, bstb, rstb, redstb, selstb, smpstb, busy, done, err, isb, pint, pbool};
  endfunction

  task automatic load_seed(input logic [7:0] s);
    @(negedge clock);
    seed_load = 1'b1;
    seed      = s;
    @(negedge clock);
    seed_load = 1'b0;
    m_lfsr    = (s == 8'h00) ? 8'h01 : s;
  endtask

  // One proposal: pulse start, watch every cycle, then check against the rules.
  task automatic run_txn(input string tag, input bit poke, output int lat, output int idx);
    int ty, exp_lat, ncl, cb, cr, crd, cs, csm, excl, redbad, extra, nstb;
    logic busy0, err_at_done, disc_at_done;
    logic [7:0] exp_red;
    m_lfsr = lfsr_step(m_lfsr);
    idx = int'(m_lfsr[1:0]);
    ty  = int'(types[2*idx +: 2]);
    ncl = (int'(nclauses) > C) ? C : int'(nclauses);
    case (ty)
      0:       exp_lat = 4;
      1:       exp_lat = nns ? 5 : 6;
      2:       exp_lat = ncl + 5;
      default: exp_lat = 2;
    endcase
    lat = -1; cb = 0; cr = 0; crd = 0; cs = 0; csm = 0; excl = 0; redbad = 0; extra = 0;
    busy0 = 1'b0; err_at_done = 1'b0; disc_at_done = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c == 0) begin
        start = 1'b0;
        busy0 = busy;
      end
      if (poke && c == 1) start = 1'b1;
      if (poke && c == 2) start = 1'b0;
      nstb = int'(bstb) + int'(rstb) + int'(selstb) + int'(smpstb) + $countones(redstb);
      if (nstb > 1) excl++;
      cb  += int'(bstb);
      cr  += int'(rstb);
      cs  += int'(selstb);
      csm += int'(smpstb);
      if (redstb != '0) begin
        exp_red = 8'h01 << crd;
        if (redstb !== exp_red) redbad++;
        crd++;
      end
      if (done) begin
        lat = c;
        err_at_done  = err;
        disc_at_done = disc_o;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " index"}, int'(idx_o), idx);
    check({tag, " busy after accept"}, busy0, 1'b1);
    check({tag, " error"}, err_at_done, ty == 3);
    check({tag, " discrete flag"}, disc_at_done, ty == 1);
    check({tag, " strobe counts"}, {cb[3:0], cr[3:0], crd[7:0], cs[3:0], csm[3:0]},
          {(ty == 0) ? 4'd1 : 4'd0, (ty == 1) ? 4'd1 : 4'd0, (ty == 2) ? 8'(ncl) : 8'd0,
           (ty == 2) ? 4'd1 : 4'd0, (ty == 2 || (ty == 1 && !nns)) ? 4'd1 : 4'd0});
    check({tag, " one strobe per cycle"}, excl, 0);
    check({tag, " reduce order"}, redbad, 0);
    if (ty == 0) begin
      check({tag, " is_boolean"}, isb, 1'b1);
      check({tag, " boolean move"}, pbool, bool_move);
    end else if (ty != 3) begin
      check({tag, " is_boolean"}, isb, 1'b0);
      check({tag, " integer move"}, pint, int_move);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (done) extra++;
    end
    check({tag, " single done"}, extra, 0);
    check({tag, " idle busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [7:0] types;
    logic [3:0] ncl;
    logic       nns;
    logic [7:0] im;
    logic [3:0] bm;
    bit         poke;
    int         exp_idx;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, idx;
    vecs[0] = '{8'h01, 8'h00, 4'd0,  1'b0, 8'd0,  4'b1010, 1'b0, 2, 4};
    vecs[1] = '{8'h01, 8'h10, 4'd0,  1'b1, 8'd7,  4'b0000, 1'b0, 2, 5};
    vecs[2] = '{8'h01, 8'h10, 4'd0,  1'b0, 8'd7,  4'b0000, 1'b1, 2, 6};
    vecs[3] = '{8'h01, 8'h20, 4'd3,  1'b0, 8'd99, 4'b0000, 1'b1, 2, 8};
    vecs[4] = '{8'h01, 8'h20, 4'd0,  1'b0, 8'd42, 4'b0000, 1'b0, 2, 5};
    vecs[5] = '{8'h01, 8'h30, 4'd0,  1'b0, 8'd0,  4'b0000, 1'b1, 2, 2};
    vecs[6] = '{8'h01, 8'h20, 4'd12, 1'b0, 8'd5,  4'b0000, 1'b0, 2, 13};
    vecs[7] = '{8'h00, 8'h00, 4'd0,  1'b0, 8'd0,  4'b0101, 1'b0, 2, 4};
    vecs[8] = '{8'h80, 8'h04, 4'd0,  1'b1, 8'd200, 4'b0000, 1'b0, 1, 5};

    // Reset values
    #12;
    check("reset outputs", all_outputs(), '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      load_seed(vecs[i].seed);
      types     = vecs[i].types;
      nclauses  = vecs[i].ncl;
      nns       = vecs[i].nns;
      int_move  = vecs[i].im;
      bool_move = vecs[i].bm;
      run_txn($sformatf("vec%0d", i), vecs[i].poke, lat, idx);
      check($sformatf("vec%0d table latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d table index", i), idx, vecs[i].exp_idx);
    end

    // Reset in the middle of a REDUCE run
    begin
      int dones;
      load_seed(8'h01);
      types    = 8'h20;
      nclauses = 4'd8;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      check("mid-reduce busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("async reset outputs", all_outputs(), '0);
      dones = 0;
      repeat (4) begin
        @(negedge clock);
        if (done) dones++;
      end
      check("no done after abort", dones, 0);
      reset_n = 1'b1;
      m_lfsr  = 8'h01;
      types   = 8'h00;
      bool_move = 4'b0110;
      run_txn("post-reset", 1'b0, lat, idx);
      check("post-reset index", idx, 2);
    end

    // Random transactions
    load_seed(8'($urandom_range(0, 255)));
    for (int t = 0; t < 150; t++) begin
      types     = 8'($urandom);
      nclauses  = 4'($urandom_range(0, 15));
      nns       = 1'($urandom);
      int_move  = 8'($urandom);
      bool_move = 4'($urandom);
      run_txn($sformatf("rand%0d", t), bit'($urandom_range(0, 1)), lat, idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
